// File: rtl/lcu_feeder.sv
// Streams a 128x128 frame from a synchronous ROM to the SAO filter in LCU raster order.
// Optional stall statistics counter enabled by defining LCU_FEEDER_STATS_EN.
module lcu_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  cfg_type,
    input  logic [4:0]  cfg_band_pos,
    input  logic        cfg_wo_class,
    input  logic [15:0] cfg_offset,
    input  logic [1:0]  cfg_size,
    output logic [13:0] iaddr,
    input  logic [7:0]  idata,
    input  logic        busy,
    output logic        in_en,
    output logic [7:0]  din,
    output logic [1:0]  ipf_type,
    output logic [4:0]  ipf_band_pos,
    output logic        ipf_wo_class,
    output logic [15:0] ipf_offset,
    output logic [1:0]  lcu_size,
    output logic [2:0]  lcu_x,
    output logic [2:0]  lcu_y,
    output logic        done
`ifdef LCU_FEEDER_STATS_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t     state_r, state_nxt_s;
    logic [6:0] c_r, r_r;
    logic [2:0] x_r, y_r;
    logic       all_issued_r;
    logic       rd_valid_r, rd_last_r;
    logic [2:0] rd_x_r, rd_y_r;
    logic       sk_valid_r, sk_last_r;
    logic [7:0] sk_data_r;
    logic [2:0] sk_x_r, sk_y_r;
    logic       out_last_r;

    logic       start_ok_s, out_ready_s, fire_s, finish_s, sk_next_s, issue_s;
    logic [2:0] sh_s, lmax_s, x_n_s, y_n_s;
    logic [6:0] nmax_s, c_n_s, r_n_s, row_s, col_s;
    logic       c_end_s, r_end_s, x_end_s, y_end_s, last_s;

    // Handshake: an address is only presented to the ROM when the skid buffer will be free to absorb its data.
    always_comb begin
        start_ok_s  = start && (cfg_size != 2'd3) && (state_r != ST_STREAM);
        out_ready_s = !in_en || !busy;
        fire_s      = in_en && !busy;
        finish_s    = fire_s && out_last_r;
        if (out_ready_s) begin
            if (sk_valid_r) begin
                sk_next_s = rd_valid_r;
            end else begin
                sk_next_s = 1'b0;
            end
        end else begin
            sk_next_s = sk_valid_r || rd_valid_r;
        end
        issue_s = (state_r == ST_STREAM) && !all_issued_r && !sk_next_s;
    end

    // Next pixel position inside the LCU grid and its frame address.
    always_comb begin
        sh_s    = 3'd4 + {1'b0, lcu_size};
        nmax_s  = (7'd16 << lcu_size) - 7'd1;
        lmax_s  = 3'd7 >> lcu_size;
        c_end_s = (c_r == nmax_s);
        r_end_s = (r_r == nmax_s);
        x_end_s = (x_r == lmax_s);
        y_end_s = (y_r == lmax_s);
        last_s  = c_end_s && r_end_s && x_end_s && y_end_s;
        c_n_s   = c_r + 7'd1;
        r_n_s   = r_r;
        x_n_s   = x_r;
        y_n_s   = y_r;
        if (c_end_s) begin
            c_n_s = 7'd0;
            if (r_end_s) begin
                r_n_s = 7'd0;
                if (x_end_s) begin
                    x_n_s = 3'd0;
                    y_n_s = y_r + 3'd1;
                end else begin
                    x_n_s = x_r + 3'd1;
                end
            end else begin
                r_n_s = r_r + 7'd1;
            end
        end else begin
            c_n_s = c_r + 7'd1;
        end
        row_s = (7'(y_n_s) << sh_s) + r_n_s;
        col_s = (7'(x_n_s) << sh_s) + c_n_s;
    end

    // Frame state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame state transitions.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = start_ok_s ? ST_STREAM : ST_IDLE;
            ST_STREAM: state_nxt_s = finish_s ? ST_DONE : ST_STREAM;
            ST_DONE:   state_nxt_s = start_ok_s ? ST_STREAM : ST_DONE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Address generation, ROM return tracking, skid buffer and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ipf_type     <= 2'd0;
            ipf_band_pos <= 5'd0;
            ipf_wo_class <= 1'b0;
            ipf_offset   <= 16'd0;
            lcu_size     <= 2'd0;
            c_r          <= 7'd0;
            r_r          <= 7'd0;
            x_r          <= 3'd0;
            y_r          <= 3'd0;
            iaddr        <= 14'd0;
            all_issued_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_last_r    <= 1'b0;
            rd_x_r       <= 3'd0;
            rd_y_r       <= 3'd0;
            sk_valid_r   <= 1'b0;
            sk_last_r    <= 1'b0;
            sk_data_r    <= 8'd0;
            sk_x_r       <= 3'd0;
            sk_y_r       <= 3'd0;
            in_en        <= 1'b0;
            din          <= 8'd0;
            lcu_x        <= 3'd0;
            lcu_y        <= 3'd0;
            out_last_r   <= 1'b0;
            done         <= 1'b0;
        end else if (start_ok_s) begin
            ipf_type     <= cfg_type;
            ipf_band_pos <= cfg_band_pos;
            ipf_wo_class <= cfg_wo_class;
            ipf_offset   <= cfg_offset;
            lcu_size     <= cfg_size;
            c_r          <= 7'd0;
            r_r          <= 7'd0;
            x_r          <= 3'd0;
            y_r          <= 3'd0;
            iaddr        <= 14'd0;
            all_issued_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            sk_valid_r   <= 1'b0;
            in_en        <= 1'b0;
            out_last_r   <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (issue_s) begin
                c_r          <= c_n_s;
                r_r          <= r_n_s;
                x_r          <= x_n_s;
                y_r          <= y_n_s;
                iaddr        <= {row_s, col_s};
                all_issued_r <= last_s;
                rd_last_r    <= last_s;
                rd_x_r       <= x_r;
                rd_y_r       <= y_r;
            end
            rd_valid_r <= issue_s;
            sk_valid_r <= sk_next_s;
            if (rd_valid_r && (!out_ready_s || sk_valid_r)) begin
                sk_data_r <= idata;
                sk_x_r    <= rd_x_r;
                sk_y_r    <= rd_y_r;
                sk_last_r <= rd_last_r;
            end
            if (out_ready_s) begin
                if (sk_valid_r) begin
                    in_en      <= 1'b1;
                    din        <= sk_data_r;
                    lcu_x      <= sk_x_r;
                    lcu_y      <= sk_y_r;
                    out_last_r <= sk_last_r;
                end else if (rd_valid_r) begin
                    in_en      <= 1'b1;
                    din        <= idata;
                    lcu_x      <= rd_x_r;
                    lcu_y      <= rd_y_r;
                    out_last_r <= rd_last_r;
                end else begin
                    in_en      <= 1'b0;
                    out_last_r <= 1'b0;
                end
            end
            if (finish_s) begin
                done <= 1'b1;
            end
        end
    end

`ifdef LCU_FEEDER_STATS_EN
    // Saturating count of cycles the filter held back a valid pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (start_ok_s) begin
            stall_cnt <= 16'd0;
        end else if (in_en && busy && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lcu_feeder.sv
// Directed self-checking bench for lcu_feeder with a behavioural synchronous frame ROM.
module tb_lcu_feeder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  cfg_type;
    logic [4:0]  cfg_band_pos;
    logic        cfg_wo_class;
    logic [15:0] cfg_offset;
    logic [1:0]  cfg_size;
    logic [13:0] iaddr;
    logic [7:0]  idata;
    logic        busy;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic [1:0]  lcu_size;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic        done;
`ifdef LCU_FEEDER_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int rom_mode = 0;

    logic [7:0] got_din [16384];
    logic [2:0] got_x   [16384];
    logic [2:0] got_y   [16384];

    lcu_feeder dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_type(cfg_type), .cfg_band_pos(cfg_band_pos), .cfg_wo_class(cfg_wo_class),
        .cfg_offset(cfg_offset), .cfg_size(cfg_size),
        .iaddr(iaddr), .idata(idata), .busy(busy), .in_en(in_en), .din(din),
        .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos), .ipf_wo_class(ipf_wo_class),
        .ipf_offset(ipf_offset), .lcu_size(lcu_size), .lcu_x(lcu_x), .lcu_y(lcu_y),
        .done(done)
`ifdef LCU_FEEDER_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input int mode, input logic [13:0] a);
        if (mode == 0) return a[7:0];
        return a[7:0] ^ {a[13:7], 1'b0} ^ 8'h5A;
    endfunction

    always @(posedge clk) idata <= rom_f(rom_mode, iaddr);

    function automatic void exp_pix(input int sz, input int k, output int addr, output int x, output int y);
        int n, per, lcu, w, r, c, lpa;
        n = 16 << sz; per = n * n; lcu = k / per; w = k % per;
        r = w / n; c = w % n; lpa = 128 / n;
        x = lcu % lpa; y = lcu / lpa;
        addr = (y * n + r) * 128 + x * n + c;
    endfunction

    function automatic int seq_errors(input int sz, input int mode, input int n, output int first_bad);
        int cnt, a, x, y;
        cnt = 0; first_bad = -1;
        for (int k = 0; k < n; k++) begin
            exp_pix(sz, k, a, x, y);
            if (got_din[k] !== rom_f(mode, 14'(a)) || got_x[k] !== 3'(x) || got_y[k] !== 3'(y)) begin
                if (cnt == 0) first_bad = k;
                cnt++;
            end
        end
        return cnt;
    endfunction

    task automatic drive_start(input logic [1:0] sz, input logic [1:0] ty, input logic [4:0] bp,
                               input logic wo, input logic [15:0] off);
        cfg_size = sz; cfg_type = ty; cfg_band_pos = bp; cfg_wo_class = wo; cfg_offset = off;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Collects transfers at negedges; busy pattern and optional mid-stream start are driven here.
    task automatic run_frame(input int stall_mode, input int target, input int inj_at,
                             output int nxfer, output int ncyc, output int first_lat,
                             output int stable_err, output int prm_chg);
        int cyc, first_cyc, last_cyc, stall_left;
        bit hold, inj_done;
        logic [7:0] h_din;
        logic [2:0] h_x, h_y;
        logic [25:0] p0, pc;
        nxfer = 0; ncyc = 0; first_lat = -1; stable_err = 0; prm_chg = 0;
        cyc = 0; first_cyc = 0; last_cyc = 0; stall_left = 0; hold = 0; inj_done = 0;
        h_din = 8'd0; h_x = 3'd0; h_y = 3'd0; p0 = 26'd0;
        while (nxfer < target && cyc < 40000) begin
            start = 1'b0;
            if (hold) begin
                if (in_en !== 1'b1 || din !== h_din || lcu_x !== h_x || lcu_y !== h_y) stable_err++;
                hold = 0;
            end
            if (stall_left > 0) begin
                busy = 1'b1; stall_left--;
            end else begin
                busy = 1'b0;
            end
            pc = {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_size};
            if (in_en === 1'b1 && busy == 1'b0) begin
                if (nxfer == 0) begin
                    first_lat = cyc; first_cyc = cyc; p0 = pc;
                end else if (pc !== p0) begin
                    prm_chg++;
                end
                got_din[nxfer] = din; got_x[nxfer] = lcu_x; got_y[nxfer] = lcu_y;
                last_cyc = cyc;
                nxfer++;
                if (stall_mode != 0 && nxfer % 64 == 0 && nxfer < 16384) stall_left = 3;
            end else if (in_en === 1'b1) begin
                hold = 1; h_din = din; h_x = lcu_x; h_y = lcu_y;
            end
            if (inj_at >= 0 && !inj_done && nxfer == inj_at) begin
                cfg_size = 2'd0; cfg_type = 2'd1; cfg_band_pos = 5'd3; cfg_wo_class = 1'b0;
                cfg_offset = 16'h0123; start = 1'b1; inj_done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        busy = 1'b0; start = 1'b0;
        ncyc = (nxfer > 0) ? last_cyc - first_cyc + 1 : 0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; busy = 1'b0;
        cfg_type = 2'd0; cfg_band_pos = 5'd0; cfg_wo_class = 1'b0; cfg_offset = 16'd0; cfg_size = 2'd0;
        repeat (3) @(negedge clk);
        checks++; if (in_en !== 1'b0) begin errors++; $display("FAIL rst_in_en got %b want 0", in_en); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (din !== 8'd0) begin errors++; $display("FAIL rst_din got %h want 00", din); end
        checks++; if (iaddr !== 14'd0) begin errors++; $display("FAIL rst_iaddr got %h want 0", iaddr); end
        checks++;
        if ({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_size, lcu_x, lcu_y} !== 32'd0) begin
            errors++; $display("FAIL rst_params got %h want 0",
                {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_size, lcu_x, lcu_y});
        end
`ifdef LCU_FEEDER_STATS_EN
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
`endif
        reset = 1'b1;
        busy = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_en !== 1'b0) begin errors++; $display("FAIL idle_in_en got %b want 0", in_en); end
        busy = 1'b0;
    endtask

    task automatic test_size0_unstalled();
        int nx, nc, lat, se, pch, bad, fb;
        rom_mode = 0;
        drive_start(2'd0, 2'd1, 5'd9, 1'b0, 16'h1234);
        run_frame(0, 16384, -1, nx, nc, lat, se, pch);
        checks++; if (nx !== 16384) begin errors++; $display("FAIL s0_count got %0d want 16384", nx); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL s0_latency got %0d want 2", lat); end
        checks++; if (nc !== 16384) begin errors++; $display("FAIL s0_cycles got %0d want 16384", nc); end
        bad = seq_errors(0, 0, nx, fb);
        checks++; if (bad !== 0) begin errors++; $display("FAIL s0_sequence got %0d bad (first %0d) want 0", bad, fb); end
        checks++; if (got_din[256] !== 8'h10) begin errors++; $display("FAIL s0_din256 got %h want 10", got_din[256]); end
        checks++; if (got_x[256] !== 3'd1 || got_y[256] !== 3'd0) begin
            errors++; $display("FAIL s0_xy256 got %0d,%0d want 1,0", got_x[256], got_y[256]); end
        checks++; if (in_en !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL s0_end got in_en=%b done=%b want 0,1", in_en, done); end
        checks++; if (pch !== 0 || ipf_type !== 2'd1 || ipf_offset !== 16'h1234) begin
            errors++; $display("FAIL s0_params got chg=%0d type=%0d off=%h want 0,1,1234", pch, ipf_type, ipf_offset); end
        busy = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (in_en !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL s0_done_hold got in_en=%b done=%b want 0,1", in_en, done); end
        busy = 1'b0;
    endtask

    task automatic test_size2_stalled();
        int nx, nc, lat, se, pch, bad, fb;
        rom_mode = 1;
        drive_start(2'd2, 2'd3, 5'd31, 1'b1, 16'hA5C3);
        run_frame(1, 16384, -1, nx, nc, lat, se, pch);
        checks++; if (nx !== 16384) begin errors++; $display("FAIL s2_count got %0d want 16384", nx); end
        bad = seq_errors(2, 1, nx, fb);
        checks++; if (bad !== 0) begin errors++; $display("FAIL s2_sequence got %0d bad (first %0d) want 0", bad, fb); end
        checks++; if (se !== 0) begin errors++; $display("FAIL s2_stall_stable got %0d changes want 0", se); end
        checks++; if (nc !== 17149) begin errors++; $display("FAIL s2_cycles got %0d want 17149", nc); end
        checks++; if (in_en !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL s2_end got in_en=%b done=%b want 0,1", in_en, done); end
`ifdef LCU_FEEDER_STATS_EN
        checks++; if (stall_cnt !== 16'd765) begin errors++; $display("FAIL s2_stall_cnt got %0d want 765", stall_cnt); end
`endif
    endtask

    task automatic test_size1();
        int nx, nc, lat, se, pch, bad, fb;
        rom_mode = 1;
        drive_start(2'd1, 2'd2, 5'd4, 1'b0, 16'h00FF);
        run_frame(0, 16384, -1, nx, nc, lat, se, pch);
        bad = seq_errors(1, 1, nx, fb);
        checks++; if (nx !== 16384 || bad !== 0) begin
            errors++; $display("FAIL s1_sequence got n=%0d bad=%0d (first %0d) want 16384,0", nx, bad, fb); end
        checks++; if (got_din[4096] !== 8'h1A) begin errors++; $display("FAIL s1_din4096 got %h want 1a", got_din[4096]); end
        checks++; if (got_x[4096] !== 3'd0 || got_y[4096] !== 3'd1) begin
            errors++; $display("FAIL s1_xy4096 got %0d,%0d want 0,1", got_x[4096], got_y[4096]); end
        checks++; if (got_x[1024] !== 3'd1 || got_y[1024] !== 3'd0) begin
            errors++; $display("FAIL s1_xy1024 got %0d,%0d want 1,0", got_x[1024], got_y[1024]); end
        checks++; if (pch !== 0 || lcu_size !== 2'd1) begin
            errors++; $display("FAIL s1_lcu_size got chg=%0d size=%0d want 0,1", pch, lcu_size); end
    endtask

    task automatic test_reset_midframe();
        int nx, nc, lat, se, pch, bad, fb;
        rom_mode = 1;
        drive_start(2'd0, 2'd2, 5'd7, 1'b1, 16'h4321);
        run_frame(0, 5000, -1, nx, nc, lat, se, pch);
        checks++; if (nx !== 5000) begin errors++; $display("FAIL mid_count got %0d want 5000", nx); end
        reset = 1'b0;
        #1;
        checks++; if (in_en !== 1'b0 || done !== 1'b0 || din !== 8'd0) begin
            errors++; $display("FAIL mid_rst_out got in_en=%b done=%b din=%h want 0,0,00", in_en, done, din); end
        checks++; if (iaddr !== 14'd0 || ipf_offset !== 16'd0 || lcu_x !== 3'd0) begin
            errors++; $display("FAIL mid_rst_regs got iaddr=%h off=%h x=%0d want 0", iaddr, ipf_offset, lcu_x); end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_en !== 1'b0) begin errors++; $display("FAIL mid_no_resume got %b want 0", in_en); end
        drive_start(2'd0, 2'd2, 5'd7, 1'b1, 16'h4321);
        run_frame(0, 300, -1, nx, nc, lat, se, pch);
        checks++; if (lat !== 2 || got_din[0] !== 8'h5A) begin
            errors++; $display("FAIL mid_restart got lat=%0d din0=%h want 2,5a", lat, got_din[0]); end
        bad = seq_errors(0, 1, nx, fb);
        checks++; if (nx !== 300 || bad !== 0) begin
            errors++; $display("FAIL mid_restart_seq got n=%0d bad=%0d want 300,0", nx, bad); end
    endtask

    task automatic test_ignored_starts();
        int nx, nc, lat, se, pch, bad, fb, seen;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive_start(2'd3, 2'd3, 5'd21, 1'b1, 16'hFFFF);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (in_en !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL sz3_in_en got %0d active cycles want 0", seen); end
        checks++; if (ipf_type !== 2'd0 || lcu_size !== 2'd0 || done !== 1'b0) begin
            errors++; $display("FAIL sz3_params got type=%0d size=%0d done=%b want 0,0,0", ipf_type, lcu_size, done); end
        rom_mode = 1;
        drive_start(2'd2, 2'd2, 5'd17, 1'b1, 16'hBEEF);
        run_frame(0, 200, 50, nx, nc, lat, se, pch);
        bad = seq_errors(2, 1, nx, fb);
        checks++; if (nx !== 200 || bad !== 0) begin
            errors++; $display("FAIL ign_sequence got n=%0d bad=%0d (first %0d) want 200,0", nx, bad, fb); end
        checks++; if (pch !== 0) begin errors++; $display("FAIL ign_param_change got %0d want 0", pch); end
        checks++;
        if (ipf_type !== 2'd2 || ipf_band_pos !== 5'd17 || ipf_wo_class !== 1'b1 ||
            ipf_offset !== 16'hBEEF || lcu_size !== 2'd2) begin
            errors++; $display("FAIL ign_params got %0d/%0d/%b/%h/%0d want 2/17/1/beef/2",
                ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_size);
        end
    endtask

    initial begin
        test_reset();
        test_size0_unstalled();
        test_size2_stalled();
        test_size1();
        test_reset_midframe();
        test_ignored_starts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
